// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared types for the iterative multiply/divide unit
// op and FSM encodings plus operand signedness helpers
package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_e;

    localparam int OP_IS_DIV_BIT = 2;
    localparam int CNT_W         = 6;

    function automatic logic a_is_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_is_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the {hi, lo} working pair
// shift-add for multiply, restoring shift-subtract for divide
module muldiv_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] sub_diff;
    logic           fits;

    // partial remainder stays below 2*divisor, so the top diff bit is the borrow
    always_comb begin
        add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        sub_diff = rem_sh - {1'b0, opnd};
        fits     = ~sub_diff[WIDTH];
        if (is_div) begin
            hi_next = fits ? sub_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative RISC-V M-extension multiply/divide
// define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise ops 4-7 return 0
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FAST_PATH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    muldiv_op_e         op_q;
    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q, result_q;
    logic               neg_q, dz_q, init_q;

    muldiv_op_e         op_in;
    logic               in_div, in_rem, a_neg, b_neg;
    logic               b_zero, ovf, skip, accept;
    logic [WIDTH-1:0]   abs_a, abs_b, skip_res;

    logic               q_div;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   word_fix, fix_res;

    assign in_ready    = (state_q == ST_IDLE) && init_q && !flush;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign result      = result_q;
    assign div_by_zero = dz_q && out_valid;

    // classify the request, take magnitudes, precompute early-exit results
    always_comb begin
        op_in  = muldiv_op_e'(op);
        in_div = DIV_EN && op[OP_IS_DIV_BIT];
        in_rem = is_rem(op_in);
        a_neg  = a_is_signed(op_in) && a[WIDTH-1];
        b_neg  = b_is_signed(op_in) && b[WIDTH-1];
        abs_a  = a_neg ? -a : a;
        abs_b  = b_neg ? -b : b;
        b_zero = (b == '0);
        ovf    = in_div && b_is_signed(op_in) &&
                 (a == MIN_NEG) && (b == '1);
        skip   = (in_div && (b_zero || ovf) && (FAST_PATH != 0)) ||
                 (op[OP_IS_DIV_BIT] && !DIV_EN);
        if (!in_div)
            skip_res = '0;
        else if (b_zero)
            skip_res = in_rem ? a : '1;
        else
            skip_res = in_rem ? '0 : a;
    end

    // sign correction and half/word selection after the last iteration
    always_comb begin
        q_div    = DIV_EN && op_q[OP_IS_DIV_BIT];
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        word_fix = is_rem(op_q) ? hi_q : lo_q;
        if (neg_q)
            word_fix = -word_fix;
        if (q_div)
            fix_res = word_fix;
        else if (op_q == OP_MUL)
            fix_res = prod_fix[WIDTH-1:0];
        else
            fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (q_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .opnd    (opnd_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // next state; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = skip ? ST_DONE : ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    // state register; init_q holds in_ready low until the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else if (accept) begin
            cnt_q  <= CNT_W'(WIDTH - 1);
            op_q   <= op_in;
            hi_q   <= '0;
            lo_q   <= in_div ? abs_a : abs_b;
            opnd_q <= in_div ? abs_b : abs_a;
            if (in_div && in_rem)
                neg_q <= a_neg;
            else
                neg_q <= (a_neg ^ b_neg) && !(in_div && b_zero);
            dz_q <= in_div && b_zero;
            if (skip)
                result_q <= skip_res;
        end else if (state_q == ST_CALC) begin
            if (cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            hi_q <= hi_step;
            lo_q <= lo_step;
        end else if (state_q == ST_FIXUP) begin
            result_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (WIDTH=32, FAST_PATH=1)
// expectations follow MUL_DIV_UNIT_DIV_EN when the divider is built
`timescale 1ns/1ps
module tb_mul_div_unit;

    localparam int W = 32;
`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, div_by_zero, busy;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_res[$];
    logic         q_dz[$];
    int           q_lat[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .FAST_PATH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    function automatic void model(input logic [2:0] o,
                                  input logic [W-1:0] x, y,
                                  output logic [W-1:0] r,
                                  output logic dz, output int lat);
        longint      sx, sy, ux, uy, q;
        logic [63:0] p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        dz  = 1'b0;
        lat = LAT;
        r   = '0;
        p   = '0;
        q   = 0;
        case (o)
            3'd0: begin p = sx * sy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            default: begin
                if (!DIV_ON) begin
                    lat = 1;
                end else if (y == '0) begin
                    dz  = 1'b1;
                    lat = 1;
                    r   = o[1] ? x : '1;
                end else if (!o[0] && x == 32'h8000_0000 && y == '1) begin
                    lat = 1;
                    r   = o[1] ? '0 : x;
                end else begin
                    case (o)
                        3'd4:    q = sx / sy;
                        3'd5:    q = ux / uy;
                        3'd6:    q = sx % sy;
                        default: q = ux % uy;
                    endcase
                    r = q[31:0];
                end
            end
        endcase
    endfunction

    task automatic drive_req(input logic [2:0] o, input logic [W-1:0] x, y);
        int n = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, y,
                        input logic [W-1:0] er, input logic ed, input int el);
        q_res.push_back(er);
        q_dz.push_back(ed);
        q_lat.push_back(el);
        drive_req(o, x, y);
    endtask

    task automatic send_model(input logic [2:0] o, input logic [W-1:0] x, y);
        logic [W-1:0] er;
        logic         ed;
        int           el;
        model(o, x, y, er, ed, el);
        send(o, x, y, er, ed, el);
    endtask

    task automatic collect(input string name, input int hold);
        int           lat = 1;
        logic [W-1:0] er;
        logic         ed;
        int           el;
        er = q_res.pop_front();
        ed = q_dz.pop_front();
        el = q_lat.pop_front();
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
        end else if (result !== er || div_by_zero !== ed || lat != el) begin
            errors++;
            $display("FAIL %s: result=%h dz=%b lat=%0d required result=%h dz=%b lat=%0d",
                     name, result, div_by_zero, lat, er, ed, el);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b result=%h in_ready=%b required 1 %h 0",
                         name, i, out_valid, result, in_ready, er);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: in_ready=%b out_valid=%b required 1 0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset: v/dz/busy/rdy=%b result=%h required 0000 0",
                     {out_valid, div_by_zero, busy, in_ready}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rdy_pre_edge: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdy_post_edge: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_mul();
        send(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT);
        collect("mul_7x-3", 0);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT);
        collect("mulhu_ones", 0);
        send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT);
        collect("mulh_ones", 0);
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT);
        collect("mulhsu_ones", 0);
        send(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, LAT);
        collect("mulh_min", 0);
    endtask

    task automatic test_div();
        int dl = DIV_ON ? LAT : 1;
        send(3'd4, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFD : 32'h0, 1'b0, dl);
        collect("div_-7_2", 0);
        send(3'd6, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0, dl);
        collect("rem_-7_2", 0);
        send(3'd5, 32'h1234, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'h0, DIV_ON, 1);
        collect("divu_zero", 0);
        send(3'd7, 32'h1234, 32'd0, DIV_ON ? 32'h1234 : 32'h0, DIV_ON, 1);
        collect("remu_zero", 0);
        send(3'd4, 32'hFFFF_FFF9, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'h0, DIV_ON, 1);
        collect("div_neg_zero", 0);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON ? 32'h8000_0000 : 32'h0, 1'b0, 1);
        collect("div_ovf", 0);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        collect("rem_ovf", 0);
        send(3'd5, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'h0, 1'b0, dl);
        collect("divu_100_7", 0);
        send(3'd6, 32'd5, 32'hFFFF_FFFD, DIV_ON ? 32'd2 : 32'h0, 1'b0, dl);
        collect("rem_5_-3", 0);
    endtask

    task automatic test_back_to_back();
        send_model(3'd0, 32'd5, 32'd9);
        collect("bp_mul", 5);
        send_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        collect("bp_next", 0);
    endtask

    task automatic test_flush();
        int seen = 0;
        drive_req(3'd0, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        @(negedge clk);
        op = 3'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: busy=%b required 0", busy);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet: out_valid cycles=%0d required 0", seen);
        end
        send(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, LAT);
        collect("mul_3x4", 0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        drive_req(3'd0, 32'h1234, 32'h5678);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid: v/dz/busy/rdy=%b result=%h required 0000 0",
                     {out_valid, div_by_zero, busy, in_ready}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_quiet: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = '1; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            send_model(o, x, y);
            collect("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are 8 to 64 and even.
REQ-002 Parameter FAST_PATH, default 1: when set to 1, divide-by-zero and signed-overflow results skip the iterative phase.
REQ-003 Port clk, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: a request is present.
REQ-006 Port in_ready, output, 1 bit: the unit can accept a request.
REQ-007 Port op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port a, input, WIDTH bits: rs1 operand (multiplicand or dividend).
REQ-009 Port b, input, WIDTH bits: rs2 operand (multiplier or divisor).
REQ-010 Port flush, input, 1 bit: abort the operation in flight.
REQ-011 Port out_valid, output, 1 bit: result is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port result, output, WIDTH bits: the selected product half, quotient or remainder.
REQ-014 Port div_by_zero, output, 1 bit: set with the result when a DIV/DIVU/REM/REMU had b == 0.
REQ-015 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CALC, FIXUP and DONE; the encoding lives in the package.
REQ-017 in_ready SHALL be 1 only in IDLE; a handshake is in_valid && in_ready.
REQ-018 On handshake, IDLE -> CALC SHALL capture op, a and b; signed ops store absolute values and record the result sign.
REQ-019 CALC SHALL run exactly WIDTH cycles of one radix-2 step each: shift-add for multiply, restoring shift-subtract for divide; a 6-bit-min counter counts down from WIDTH-1.
REQ-020 When the counter reaches 0, CALC -> FIXUP; FIXUP SHALL apply sign correction (two's-complement negate) and select the output half/word, then -> DONE.
REQ-021 Latency from handshake to out_valid SHALL be WIDTH+2 cycles.
REQ-022 DONE SHALL hold out_valid and result stable until out_ready; on out_valid && out_ready -> IDLE, with in_ready high the following cycle (no same-cycle re-accept).
REQ-023 MUL SHALL return product[WIDTH-1:0]; MULH, MULHSU and MULHU SHALL return product[2*WIDTH-1:WIDTH] with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-024 Divide by zero SHALL give DIV/DIVU quotient all-ones and REM/REMU remainder = a, with div_by_zero = 1.
REQ-025 Signed overflow (a = most-negative, b = -1) SHALL give DIV = a and REM = 0, with div_by_zero = 0.
REQ-026 With FAST_PATH=1, the REQ-024/REQ-025 cases SHALL go IDLE -> DONE directly, for a latency of 1; with FAST_PATH=0 they traverse CALC and FIXUP and give the same values.
REQ-027 The REM sign SHALL follow the dividend; the DIV sign is sign(a) xor sign(b); a zero quotient or remainder is never negated to a nonzero value.
REQ-028 flush in any state SHALL force IDLE on the next edge and drop out_valid; flush has priority over every transition, and in_valid while flush is high is not accepted.
REQ-029 in_valid, op, a and b SHALL be ignored outside IDLE.

Reset
REQ-030 While rst_n = 0: state = IDLE, counter = 0, out_valid = 0, result = 0, div_by_zero = 0, busy = 0, in_ready = 0.
REQ-031 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-operation discards the operation with no output.

Configuration
REQ-032 Macro MUL_DIV_UNIT_DIV_EN defined: all 8 ops are supported.
REQ-033 Macro MUL_DIV_UNIT_DIV_EN undefined: the divider datapath is absent; ops 4-7 complete IDLE -> DONE in 1 cycle with result = 0 and div_by_zero = 0.

Structure
REQ-034 Package mul_div_pkg SHALL hold the op enum (muldiv_op_e), the state enum (muldiv_state_e) and localparam OP_IS_DIV_BIT = 2.
REQ-035 One combinational sub-module, muldiv_step, SHALL hold one shift-add or shift-subtract iteration, parametrised by WIDTH.

Verification
REQ-036 MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, out_valid at cycle 34 after handshake.
REQ-037 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-038 DIV a=-7, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-039 DIVU a=0x1234, b=0 -> 0xFFFFFFFF with div_by_zero=1 in 1 cycle (FAST_PATH=1); DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-040 out_ready held low for 5 cycles in DONE -> result stable and in_ready=0 throughout; the next request is accepted 1 cycle after release.
REQ-041 flush at CALC cycle 10 -> IDLE next cycle, no out_valid; the following MUL 3*4 returns 12; rst_n pulsed mid-CALC -> all outputs at their reset values.
